// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and helpers for the 10G PHY receive path.
// Sync headers are listed as hdr[1:0], in the order the bits arrive on the wire.
package eth_phy_10g_pkg;

  localparam int BLOCK_WIDTH = 66;
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Reverses the low 'width' bits of d. Result bits at 'width' and above are zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] d, input int width);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) r[i] = d[6'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_gearbox.sv
// RX gearbox: packs IN_WIDTH-bit transceiver words into 66-bit blocks, with one-bit slips.
// Optional `GEARBOX_STATS_EN adds the slip and block counters.
module eth_phy_10g_rx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  bitslip,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_valid
`ifdef GEARBOX_STATS_EN
  ,
  output logic [15:0]           stat_slip_count,
  output logic [31:0]           stat_block_count
`endif
);

  localparam int BUF_W = BLOCK_WIDTH - 1 + IN_WIDTH;
  localparam int CNT_W = $clog2(BUF_W + 1);

  logic [IN_WIDTH-1:0] word;
  logic [BUF_W-1:0]    buf_q;
  logic [BUF_W-1:0]    v;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    n;
  logic                bs_q;
  logic                slip_pend;
  logic                slip_req;
  logic                slip_apply;
  logic                block_ready;

  generate
    if (BIT_REVERSE) begin : g_rev
      assign word = IN_WIDTH'(bit_reverse(64'(in_data), IN_WIDTH));
    end else begin : g_norev
      assign word = in_data;
    end
  endgenerate

  // Bits beyond cnt are always zero, so appending is a plain OR at offset cnt.
  // A slip drops the oldest buffered bit; with nothing buffered it stays pending.
  always_comb begin
    slip_req = slip_pend | (bitslip & ~bs_q);
    v        = buf_q;
    n        = cnt;
    if (in_valid) begin
      v = buf_q | (BUF_W'(word) << cnt);
      n = cnt + CNT_W'(IN_WIDTH);
    end
    slip_apply = slip_req && (n != '0);
    if (slip_apply) begin
      v = v >> 1;
      n = n - CNT_W'(1);
    end
    block_ready = (n >= CNT_W'(BLOCK_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      cnt       <= '0;
      bs_q      <= 1'b0;
      slip_pend <= 1'b0;
      out_data  <= '0;
      out_hdr   <= '0;
      out_valid <= 1'b0;
    end else begin
      bs_q      <= bitslip;
      slip_pend <= slip_req & ~slip_apply;
      if (block_ready) begin
        out_hdr   <= v[HDR_WIDTH-1:0];
        out_data  <= v[BLOCK_WIDTH-1:HDR_WIDTH];
        out_valid <= 1'b1;
        buf_q     <= v >> BLOCK_WIDTH;
        cnt       <= n - CNT_W'(BLOCK_WIDTH);
      end else begin
        out_valid <= 1'b0;
        buf_q     <= v;
        cnt       <= n;
      end
    end
  end

`ifdef GEARBOX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_slip_count  <= '0;
      stat_block_count <= '0;
    end else begin
      if (slip_apply)  stat_slip_count  <= stat_slip_count + 16'd1;
      if (block_ready) stat_block_count <= stat_block_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Directed bench for eth_phy_10g_rx_gearbox (IN_WIDTH=32) with a bit-queue reference model.
// Counter checks are compiled in when GEARBOX_STATS_EN is defined.
module tb_eth_phy_10g_rx_gearbox;
  import eth_phy_10g_pkg::*;

  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          bitslip = 1'b0;
  logic [63:0]   out_data;
  logic [1:0]    out_hdr;
  logic          out_valid;
`ifdef GEARBOX_STATS_EN
  logic [15:0]   stat_slip_count;
  logic [31:0]   stat_block_count;
`endif

  int checks = 0;
  int errors = 0;

  bit          mq[$];
  bit          m_pend;
  bit          m_bs_prev;
  logic [65:0] exp_blk;
  logic        exp_valid;
  logic        stream_bits[0:2047];
  int          stream_len;
  logic [63:0] cap_data[$];
  logic [1:0]  cap_hdr[$];

  always #5 clk = ~clk;

  eth_phy_10g_rx_gearbox #(
    .IN_WIDTH(IW), .DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .bitslip(bitslip),
    .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid)
`ifdef GEARBOX_STATS_EN
    , .stat_slip_count(stat_slip_count), .stat_block_count(stat_block_count)
`endif
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] capData(input int i);
    return (i < cap_data.size()) ? cap_data[i] : 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  function automatic logic [1:0] capHdr(input int i);
    return (i < cap_hdr.size()) ? cap_hdr[i] : 2'bxx;
  endfunction

  task automatic checkOutput();
    checkVal("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid && out_valid === 1'b1) begin
      checkVal("out_data", out_data, exp_blk[65:2]);
      checkVal("out_hdr", 64'(out_hdr), 64'(exp_blk[1:0]));
      cap_data.push_back(out_data);
      cap_hdr.push_back(out_hdr);
    end
  endtask

  // Reference: wire bits queue up in arrival order, a slip pops the oldest one.
  task automatic applyStimulus(input logic [IW-1:0] d, input logic v, input logic bs);
    @(negedge clk);
    in_data  = d;
    in_valid = v;
    bitslip  = bs;
    if (bs && !m_bs_prev) m_pend = 1'b1;
    m_bs_prev = bs;
    if (v) for (int i = 0; i < IW; i++) mq.push_back(d[i]);
    if (m_pend && mq.size() > 0) begin
      void'(mq.pop_front());
      m_pend = 1'b0;
    end
    exp_valid = 1'b0;
    if (mq.size() >= 66) begin
      for (int i = 0; i < 66; i++) exp_blk[i] = mq.pop_front();
      exp_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bitslip  = 1'b0;
    #1;
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_out_data", out_data, 64'd0);
    checkVal("rst_out_hdr", 64'(out_hdr), 64'd0);
`ifdef GEARBOX_STATS_EN
    checkVal("rst_slip_count", 64'(stat_slip_count), 64'd0);
    checkVal("rst_block_count", 64'(stat_block_count), 64'd0);
`endif
    mq.delete();
    m_pend    = 1'b0;
    m_bs_prev = 1'b0;
    exp_valid = 1'b0;
    cap_data.delete();
    cap_hdr.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic buildStream(input int junk_n, input logic [7:0] junk, input int nblk);
    logic [65:0] blk;
    stream_len = 0;
    for (int i = 0; i < junk_n; i++) begin
      stream_bits[stream_len] = junk[i];
      stream_len++;
    end
    for (int k = 0; k < nblk; k++) begin
      blk = {64'h0123456789ABCDEF + 64'(k), SYNC_CTRL};
      for (int i = 0; i < 66; i++) begin
        stream_bits[stream_len] = blk[i];
        stream_len++;
      end
    end
  endtask

  function automatic logic [IW-1:0] streamWord(input int w);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = (w * IW + i < stream_len) ? stream_bits[w * IW + i] : 1'b0;
    return r;
  endfunction

  initial begin
    m_pend    = 1'b0;
    m_bs_prev = 1'b0;
    exp_valid = 1'b0;

    #3;
    checkVal("init_out_valid", 64'(out_valid), 64'd0);
    checkVal("init_out_data", out_data, 64'd0);
    checkVal("init_out_hdr", 64'(out_hdr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] aligned stream");
    buildStream(0, 8'h00, 16);
    for (int w = 0; w < 33; w++) begin
      applyStimulus(streamWord(w), 1'b1, 1'b0);
      if (w == 1) checkVal("latency_word2", 64'(out_valid), 64'd0);
      if (w == 2) checkVal("latency_word3", 64'(out_valid), 64'd1);
    end
    checkVal("aligned_count", 64'(cap_data.size()), 64'd16);
    checkVal("aligned_first_data", capData(0), 64'h0123456789ABCDEF);
    checkVal("aligned_first_hdr", 64'(capHdr(0)), 64'(2'b01));
    checkVal("aligned_last_data", capData(15), 64'h0123456789ABCDFE);
`ifdef GEARBOX_STATS_EN
    checkVal("aligned_block_count", 64'(stat_block_count), 64'd16);
`endif

    $display("[TB] gapped stream");
    cap_data.delete();
    cap_hdr.delete();
    for (int w = 0; w < 33; w++) begin
      applyStimulus(streamWord(w), 1'b1, 1'b0);
      applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0);
    end
    checkVal("gapped_count", 64'(cap_data.size()), 64'd16);
    checkVal("gapped_last_data", capData(15), 64'h0123456789ABCDFE);
`ifdef GEARBOX_STATS_EN
    checkVal("gapped_block_count", 64'(stat_block_count), 64'd32);
`endif

    $display("[TB] misaligned stream with five slips");
    doReset();
    buildStream(5, 8'b0001_1100, 20);
    for (int w = 0; w < 5; w++) applyStimulus(streamWord(w), 1'b1, 1'b0);
    checkVal("misaligned_hdr", 64'(capHdr(0)), 64'(2'b00));
    for (int p = 0; p < 5; p++) begin
      applyStimulus('0, 1'b0, 1'b1);
      repeat (8) applyStimulus('0, 1'b0, 1'b0);
    end
`ifdef GEARBOX_STATS_EN
    checkVal("slip_count_5", 64'(stat_slip_count), 64'd5);
`endif
    for (int w = 5; w < 42; w++) applyStimulus(streamWord(w), 1'b1, 1'b0);
    checkVal("relock_count", 64'(cap_data.size()), 64'd20);
    checkVal("relock_hdr", 64'(capHdr(2)), 64'(2'b01));
    checkVal("relock_data", capData(2), 64'h0123456789ABCDF1);
    checkVal("relock_last_data", capData(19), 64'h0123456789ABCE02);

    $display("[TB] bitslip held three cycles");
    repeat (3) applyStimulus('0, 1'b0, 1'b1);
    repeat (2) applyStimulus('0, 1'b0, 1'b0);
`ifdef GEARBOX_STATS_EN
    checkVal("slip_count_held", 64'(stat_slip_count), 64'd6);
`endif
    buildStream(0, 8'h00, 2);
    for (int w = 0; w < 4; w++) applyStimulus(streamWord(w), 1'b1, 1'b0);

    $display("[TB] slip pending at empty buffer");
    doReset();
    applyStimulus('0, 1'b0, 1'b1);
    repeat (2) applyStimulus('0, 1'b0, 1'b0);
    buildStream(0, 8'h00, 16);
    for (int w = 0; w < 33; w++) applyStimulus(streamWord(w), 1'b1, 1'b0);
    checkVal("shifted_count", 64'(cap_data.size()), 64'd15);
    checkVal("shifted_first_hdr", 64'(capHdr(0)), 64'(2'b10));
`ifdef GEARBOX_STATS_EN
    checkVal("shifted_slip_count", 64'(stat_slip_count), 64'd1);
    checkVal("shifted_block_count", 64'(stat_block_count), 64'd15);
`endif

    $display("[TB] reset mid-run");
    applyStimulus(32'hA5A5_A5A5, 1'b1, 1'b0);
    checkVal("pre_reset_valid", 64'(out_valid), 64'd1);
    doReset();
    applyStimulus(32'h1234_5678, 1'b1, 1'b0);
    checkVal("post_reset_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
